// File: rtl/axi4l2apb.sv
// rtl/axi4l2apb.sv - AXI4-Lite slave to APB master bridge, one transaction in flight
module axi4l2apb #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] apb_paddr,
    output logic        apb_pwrite,
    output logic [31:0] apb_pwdata,
    output logic [3:0]  apb_pstrb,
    output logic        apb_psel,
    output logic        apb_penable,
    input  logic [31:0] apb_prdata,
    input  logic        apb_pready,
    input  logic        apb_pslverr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WRESP,
        S_RRESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state_q;
    logic        last_wr_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic [3:0]  pstrb_q;
    logic        pwrite_q;
    logic        psel_q;
    logic        penable_q;
    logic [31:0] rdata_q;
    logic [1:0]  resp_q;
    logic [31:0] tcnt_q;

    logic in_idle;
    logic wr_elig;
    logic rd_elig;
    logic grant_wr;
    logic grant_rd;
    logic timeout_hit;

    // Round-robin grant: the type not served last wins a tie; ready only in idle and out of reset
    always_comb begin
        in_idle  = (state_q == S_IDLE) && aresetn;
        wr_elig  = axi_awvalid && axi_wvalid;
        rd_elig  = axi_arvalid;
        grant_wr = in_idle && wr_elig && (!rd_elig || !last_wr_q);
        grant_rd = in_idle && rd_elig && !grant_wr;
    end

    // The last stalled ACCESS cycle is the one where the counter already holds TIMEOUT-1
    assign timeout_hit = (TIMEOUT != 0) && !apb_pready && (tcnt_q == TIMEOUT - 1);

    assign axi_awready = grant_wr;
    assign axi_wready  = grant_wr;
    assign axi_arready = grant_rd;
    assign axi_bvalid  = (state_q == S_WRESP);
    assign axi_rvalid  = (state_q == S_RRESP);
    assign axi_bresp   = resp_q;
    assign axi_rresp   = resp_q;
    assign axi_rdata   = rdata_q;
    assign apb_paddr   = paddr_q;
    assign apb_pwrite  = pwrite_q;
    assign apb_pwdata  = pwdata_q;
    assign apb_pstrb   = pstrb_q;
    assign apb_psel    = psel_q;
    assign apb_penable = penable_q;

    // Bridge FSM: accept one AXI request, run SETUP/ACCESS on APB, hold the AXI response until taken
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            tcnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_wr) begin
                        paddr_q   <= axi_awaddr;
                        pwdata_q  <= axi_wdata;
                        pstrb_q   <= axi_wstrb;
                        pwrite_q  <= 1'b1;
                        last_wr_q <= 1'b1;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= S_SETUP;
                    end else if (grant_rd) begin
                        paddr_q   <= axi_araddr;
                        pstrb_q   <= 4'b0000;
                        pwrite_q  <= 1'b0;
                        last_wr_q <= 1'b0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    tcnt_q    <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (apb_pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        resp_q    <= apb_pslverr ? RESP_SLVERR : RESP_OKAY;
                        if (!pwrite_q) begin
                            rdata_q <= apb_prdata;
                        end
                        state_q   <= pwrite_q ? S_WRESP : S_RRESP;
                    end else if (timeout_hit) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        resp_q    <= RESP_SLVERR;
                        if (!pwrite_q) begin
                            rdata_q <= '0;
                        end
                        state_q   <= pwrite_q ? S_WRESP : S_RRESP;
                    end else begin
                        tcnt_q <= tcnt_q + 32'd1;
                    end
                end
                S_WRESP: begin
                    if (axi_bready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_RRESP: begin
                    if (axi_rready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l2apb.sv
// tb/tb_axi4l2apb.sv - table-driven bench for the AXI4-Lite to APB bridge
module tb_axi4l2apb;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] apb_paddr;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [3:0]  apb_pstrb;
    logic        apb_psel;
    logic        apb_penable;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axi4l2apb #(.TIMEOUT(4)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .apb_paddr   (apb_paddr),
        .apb_pwrite  (apb_pwrite),
        .apb_pwdata  (apb_pwdata),
        .apb_pstrb   (apb_pstrb),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_pslverr (apb_pslverr)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          waits;
        logic        err;
        logic [31:0] prd;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        @(negedge aclk);
        if (v.wr) begin
            axi_awvalid = 1'b1; axi_wvalid = 1'b1;
            axi_awaddr = v.addr; axi_wdata = v.data; axi_wstrb = v.strb;
        end else begin
            axi_arvalid = 1'b1; axi_araddr = v.addr;
        end
        #1;
        chk("accept_awready", {31'd0, axi_awready}, {31'd0, v.wr});
        chk("accept_wready", {31'd0, axi_wready}, {31'd0, v.wr});
        chk("accept_arready", {31'd0, axi_arready}, {31'd0, !v.wr});
        @(negedge aclk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        axi_awaddr = 32'hFFFF_FFFF; axi_araddr = 32'hFFFF_FFFF;
        axi_wdata = 32'h5A5A_5A5A; axi_wstrb = 4'hF;
        #1;
        chk("setup_psel", {31'd0, apb_psel}, 32'd1);
        chk("setup_penable", {31'd0, apb_penable}, 32'd0);
        chk("setup_paddr", apb_paddr, v.addr);
        chk("setup_pwrite", {31'd0, apb_pwrite}, {31'd0, v.wr});
        chk("setup_pstrb", {28'd0, apb_pstrb}, v.wr ? {28'd0, v.strb} : 32'd0);
        if (v.wr) chk("setup_pwdata", apb_pwdata, v.data);
        for (int k = 0; k <= v.waits; k++) begin
            @(negedge aclk);
            apb_pready = (k == v.waits);
            apb_pslverr = v.err;
            apb_prdata = v.prd;
            #1;
            chk("access_psel", {31'd0, apb_psel}, 32'd1);
            chk("access_penable", {31'd0, apb_penable}, 32'd1);
            chk("access_paddr", apb_paddr, v.addr);
            if (v.wr) chk("access_pwdata", apb_pwdata, v.data);
        end
        @(negedge aclk);
        apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = 32'hBAD0_BAD0;
        #1;
        chk("resp_psel", {31'd0, apb_psel}, 32'd0);
        for (int h = 0; h < 2; h++) begin
            if (v.wr) begin
                chk("bvalid", {31'd0, axi_bvalid}, 32'd1);
                chk("bresp", {30'd0, axi_bresp}, {30'd0, v.exp_resp});
            end else begin
                chk("rvalid", {31'd0, axi_rvalid}, 32'd1);
                chk("rresp", {30'd0, axi_rresp}, {30'd0, v.exp_resp});
                chk("rdata", axi_rdata, v.exp_rdata);
            end
            if (h == 0) begin
                @(negedge aclk); #1;
            end
        end
        axi_bready = v.wr; axi_rready = !v.wr;
        @(negedge aclk);
        axi_bready = 1'b0; axi_rready = 1'b0;
        #1;
        chk("valid_dropped", {30'd0, axi_bvalid, axi_rvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int stray;

        vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h3, 0, 1'b0, 32'h0, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 3, 1'b0, 32'h1234_5678, 2'b00, 32'h1234_5678};
        vecs[2] = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1'b1, 32'hAAAA_5555, 2'b10, 32'hAAAA_5555};
        vecs[3] = '{1'b1, 32'h0000_0044, 32'h0102_0304, 4'hF, 0, 1'b0, 32'h0, 2'b00, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_0048, 32'hCAFE_F00D, 4'h9, 2, 1'b1, 32'h0, 2'b10, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_004C, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_CAFE, 2'b00, 32'h0BAD_CAFE};

        aresetn = 1'b0;
        axi_awaddr = 32'h0; axi_wdata = 32'h0; axi_wstrb = 4'h0; axi_araddr = 32'h0;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        axi_bready = 1'b0; axi_rready = 1'b0;
        apb_prdata = 32'h0; apb_pready = 1'b0; apb_pslverr = 1'b0;

        // Reset: readies gated, everything cleared
        @(negedge aclk); @(negedge aclk); #1;
        chk("reset_readies", {29'd0, axi_awready, axi_wready, axi_arready}, 32'd0);
        chk("reset_psel_penable", {30'd0, apb_psel, apb_penable}, 32'd0);
        chk("reset_valids", {30'd0, axi_bvalid, axi_rvalid}, 32'd0);
        chk("reset_paddr", apb_paddr, 32'd0);
        chk("reset_pwdata", apb_pwdata, 32'd0);
        chk("reset_pstrb_pwrite", {27'd0, apb_pstrb, apb_pwrite}, 32'd0);
        chk("reset_rdata", axi_rdata, 32'd0);
        chk("reset_resp", {28'd0, axi_bresp, axi_rresp}, 32'd0);

        // Simultaneous write and read from reset: write first, read next
        axi_awaddr = 32'h0000_0100; axi_wdata = 32'h1111_2222; axi_wstrb = 4'hC;
        axi_araddr = 32'h0000_0200;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("arb_awready", {31'd0, axi_awready}, 32'd1);
        chk("arb_arready_first", {31'd0, axi_arready}, 32'd0);
        @(negedge aclk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        #1;
        chk("arb_setup_pwrite", {31'd0, apb_pwrite}, 32'd1);
        chk("arb_arready_setup", {31'd0, axi_arready}, 32'd0);
        @(negedge aclk);
        apb_pready = 1'b1;
        #1;
        chk("arb_arready_access", {31'd0, axi_arready}, 32'd0);
        @(negedge aclk);
        apb_pready = 1'b0;
        #1;
        chk("arb_bvalid", {31'd0, axi_bvalid}, 32'd1);
        chk("arb_arready_wresp", {31'd0, axi_arready}, 32'd0);
        axi_bready = 1'b1;
        @(negedge aclk);
        axi_bready = 1'b0;
        #1;
        chk("arb_arready_second", {31'd0, axi_arready}, 32'd1);
        @(negedge aclk);
        axi_arvalid = 1'b0;
        #1;
        chk("arb_read_pwrite", {31'd0, apb_pwrite}, 32'd0);
        chk("arb_read_paddr", apb_paddr, 32'h0000_0200);
        @(negedge aclk);
        apb_pready = 1'b1; apb_prdata = 32'h7777_8888;
        @(negedge aclk);
        apb_pready = 1'b0;
        #1;
        chk("arb_rdata", axi_rdata, 32'h7777_8888);
        axi_rready = 1'b1;
        @(negedge aclk);
        axi_rready = 1'b0;

        // Table of single transfers
        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i]);
        end

        // Timeout: pready stuck low on a read, ACCESS must last exactly 4 cycles
        @(negedge aclk);
        axi_arvalid = 1'b1; axi_araddr = 32'h0000_0080; apb_prdata = 32'hFFFF_0000;
        #1;
        chk("to_arready", {31'd0, axi_arready}, 32'd1);
        @(negedge aclk);
        axi_arvalid = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk); #1;
            if (apb_psel && apb_penable) acc++;
            else break;
        end
        chk("to_access_cycles", acc, 32'd4);
        chk("to_rvalid", {31'd0, axi_rvalid}, 32'd1);
        chk("to_rresp", {30'd0, axi_rresp}, 32'd2);
        chk("to_rdata", axi_rdata, 32'd0);
        axi_rready = 1'b1;
        @(negedge aclk);
        axi_rready = 1'b0;

        // Reset pulse during ACCESS aborts the transfer without a response
        @(negedge aclk);
        axi_arvalid = 1'b1; axi_araddr = 32'h0000_0090;
        @(negedge aclk);
        axi_arvalid = 1'b0;
        @(negedge aclk); #1;
        chk("abort_in_access", {31'd0, apb_penable}, 32'd1);
        aresetn = 1'b0;
        @(negedge aclk); #1;
        chk("abort_psel", {30'd0, apb_psel, apb_penable}, 32'd0);
        aresetn = 1'b1;
        apb_pready = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk); #1;
            if (axi_bvalid || axi_rvalid || apb_psel) stray++;
        end
        apb_pready = 1'b0;
        chk("abort_no_response", stray, 32'd0);
        run_xfer(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
